// File: rtl/noc_pkg.sv
// Shared mesh NoC definitions: packet width, destination field positions
// and the switch port naming used by the router datapath.
package noc_pkg;

  localparam int WIDTH = 39;

  localparam int X_MSB = 36;
  localparam int X_LSB = 33;
  localparam int Y_MSB = 32;
  localparam int Y_LSB = 29;

  typedef enum logic [2:0] {
    UP    = 3'd0,
    DOWN  = 3'd1,
    LEFT  = 3'd2,
    RIGHT = 3'd3,
    LOCAL = 3'd4
  } port_e;

  function automatic logic [X_MSB-X_LSB:0] dest_x(input logic [WIDTH-1:0] pkt);
    return pkt[X_MSB:X_LSB];
  endfunction

  function automatic logic [Y_MSB-Y_LSB:0] dest_y(input logic [WIDTH-1:0] pkt);
    return pkt[Y_MSB:Y_LSB];
  endfunction

endpackage

// File: rtl/rr_port_arbiter_if.sv
// Request/output bundle of one router output link arbiter. The slave view
// is the arbiter itself; the master view is whatever feeds and drains it.
interface rr_port_arbiter_if
  import noc_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int WIDTH = noc_pkg::WIDTH
);

  localparam int IDW = $clog2(N_IN);

  logic [N_IN-1:0]       req_valid;
  logic [N_IN*WIDTH-1:0] req_data;
  logic [N_IN-1:0]       req_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic                  out_ready;
  logic [IDW-1:0]        grant_id;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, grant_id
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, grant_id
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating priority picker: finds the first set request starting at ptr and
// wrapping around, returning both a one-hot grant and its encoded index.
module rr_pick
  import noc_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] pos;

  // Walk the requests in rotated order and keep only the first hit.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = IW'((int'(ptr) + k) % N);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/rr_port_arbiter.sv
// Round-robin arbiter sharing one router output link between N_IN inputs.
// The winning packet is captured into a single output register that can be
// refilled every cycle while downstream is ready; per-input grant counters
// saturate and are readable through stats_sel/stats_count.
module rr_port_arbiter
  import noc_pkg::*;
#(
  parameter int WIDTH = noc_pkg::WIDTH,
  parameter int N_IN  = 4,
  parameter int CNT_W = 16,
  parameter int IDW   = $clog2(N_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  rr_port_arbiter_if.slave bus,
  input  logic [IDW-1:0]   stats_sel,
  output logic [CNT_W-1:0] stats_count
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       state;
  logic [IDW-1:0]   ptr;
  logic [N_IN-1:0]  grant;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   ptr_next;
  logic             accept;
  logic [WIDTH-1:0] win_data;
  logic [CNT_W-1:0] count [N_IN];

  rr_pick #(
    .N  (N_IN),
    .IW (IDW)
  ) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (winner)
  );

  // A new packet can enter when the register is free or is being drained.
  assign accept        = (|bus.req_valid) && ((state == EMPTY) || bus.out_ready);
  assign bus.req_ready = (accept && rst_n) ? grant : '0;
  assign bus.out_valid = (state == FULL);
  assign win_data      = bus.req_data[int'(winner)*WIDTH +: WIDTH];
  assign ptr_next      = (winner == IDW'(N_IN - 1)) ? '0 : winner + 1'b1;

  // Output register, round-robin pointer and EMPTY/FULL state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      ptr          <= '0;
      bus.out_data <= '0;
      bus.grant_id <= '0;
    end else if (accept) begin
      state        <= FULL;
      ptr          <= ptr_next;
      bus.out_data <= win_data;
      bus.grant_id <= winner;
    end else if ((state == FULL) && bus.out_ready) begin
      state <= EMPTY;
    end
  end

  // Saturating grant counters, one per requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) begin
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (accept && grant[i] && (count[i] != '1)) begin
          count[i] <= count[i] + 1'b1;
        end
      end
    end
  end

  // Combinational statistics read; shows the value before any same-cycle increment.
  always_comb begin
    stats_count = '0;
    if (int'(stats_sel) < N_IN) begin
      stats_count = count[stats_sel];
    end
  end

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Directed bench for rr_port_arbiter: single request, wrap/skip, fairness,
// backpressure, asynchronous reset and counter saturation (CNT_W=4).
module tb_rr_port_arbiter;

  localparam int N  = 4;
  localparam int W  = 39;
  localparam int CW = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [IW-1:0] statsSel;
  logic [CW-1:0] statsCount;

  int assertCount = 0;
  int failCount   = 0;

  logic [W-1:0] pkt [N];

  rr_port_arbiter_if #(.N_IN(N), .WIDTH(W)) bus ();

  rr_port_arbiter #(
    .WIDTH (W),
    .N_IN  (N),
    .CNT_W (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .stats_sel   (statsSel),
    .stats_count (statsCount)
  );

  // Free-running clock, rising edge active.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic ready);
    bus.req_valid = valid;
    bus.out_ready = ready;
    for (int i = 0; i < N; i++) begin
      bus.req_data[i*W +: W] = pkt[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkReg(input string tag, input logic vld, input int gid, input logic [W-1:0] data);
    checkOutput({tag, ".out_valid"}, 64'(bus.out_valid), 64'(vld));
    checkOutput({tag, ".grant_id"}, 64'(bus.grant_id), 64'(gid));
    checkOutput({tag, ".out_data"}, 64'(bus.out_data), 64'(data));
  endtask

  task automatic checkReady(input string tag, input logic [N-1:0] expected);
    #1;
    checkOutput({tag, ".req_ready"}, 64'(bus.req_ready), 64'(expected));
  endtask

  task automatic checkStats(input string tag, input int sel, input int expected);
    statsSel = IW'(sel);
    #1;
    checkOutput(tag, 64'(statsCount), 64'(expected));
  endtask

  initial begin
    pkt[0] = 39'h0A_0000_0001;
    pkt[1] = 39'h15_5555_1111;
    pkt[2] = 39'h11000E0508;
    pkt[3] = 39'h3C_ABCD_3333;
    statsSel = '0;
    rst_n    = 1'b0;
    applyStimulus(4'b0000, 1'b0);

    $display("[TB] reset state");
    tick();
    tick();
    checkReg("reset", 1'b0, 0, '0);
    checkReady("reset", 4'b0000);
    checkStats("reset.count0", 0, 0);
    rst_n = 1'b1;

    $display("[TB] single requester");
    applyStimulus(4'b0100, 1'b1);
    checkReady("single", 4'b0100);
    tick();
    checkReg("single", 1'b1, 2, pkt[2]);
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("single.drain", 64'(bus.out_valid), 64'(1'b0));

    $display("[TB] wrap and skip");
    applyStimulus(4'b0011, 1'b1);
    checkReady("wrap0", 4'b0001);
    tick();
    checkReg("wrap0", 1'b1, 0, pkt[0]);
    applyStimulus(4'b0010, 1'b1);
    checkReady("wrap1", 4'b0010);
    tick();
    checkReg("wrap1", 1'b1, 1, pkt[1]);
    applyStimulus(4'b1000, 1'b1);
    checkReady("wrap3", 4'b1000);
    tick();
    checkReg("wrap3", 1'b1, 3, pkt[3]);
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("wrap.drain", 64'(bus.out_valid), 64'(1'b0));

    $display("[TB] fairness with all inputs valid");
    applyStimulus(4'b1111, 1'b1);
    for (int k = 0; k < 6; k++) begin
      checkReady($sformatf("fair%0d", k), 4'(1 << (k % 4)));
      tick();
      checkReg($sformatf("fair%0d", k), 1'b1, k % 4, pkt[k % 4]);
    end

    $display("[TB] backpressure");
    applyStimulus(4'b1111, 1'b0);
    for (int k = 0; k < 5; k++) begin
      checkReady($sformatf("bp%0d", k), 4'b0000);
      tick();
      checkReg($sformatf("bp%0d", k), 1'b1, 1, pkt[1]);
    end
    applyStimulus(4'b1111, 1'b1);
    checkReady("bp.release", 4'b0100);
    checkStats("bp.preinc", 2, 2);
    tick();
    checkReg("bp.release", 1'b1, 2, pkt[2]);
    checkStats("stats.count0", 0, 3);
    checkStats("stats.count2", 2, 3);
    checkStats("stats.count3", 3, 2);

    $display("[TB] asynchronous reset while full");
    #1;
    rst_n = 1'b0;
    #1;
    checkReg("areset", 1'b0, 0, '0);
    checkReady("areset", 4'b0000);
    checkStats("areset.count2", 2, 0);
    tick();
    rst_n = 1'b1;
    checkReady("restart", 4'b0001);
    tick();
    checkReg("restart", 1'b1, 0, pkt[0]);

    $display("[TB] counter saturation");
    rst_n = 1'b0;
    applyStimulus(4'b0010, 1'b1);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      checkReady($sformatf("sat%0d", k), 4'b0010);
      tick();
      if (k == 14) begin
        checkStats("sat.count1_at15", 1, 15);
      end
    end
    checkReg("sat.last", 1'b1, 1, pkt[1]);
    checkStats("sat.count1", 1, 15);
    checkStats("sat.count0", 0, 0);
    checkStats("sat.count2", 2, 0);
    checkStats("sat.count3", 3, 0);

    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("final.drain", 64'(bus.out_valid), 64'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/rr_port_arbiter.md
Name: rr_port_arbiter

Overview:
- Clocked round-robin arbiter that shares one router output link among N_IN input-side requesters (e.g. the up/down/left/right/local switch outputs that target the same port).
- Each winning 39-bit packet is captured into a single output register, which acts as a pipeline stage.
- Provides fair access, valid/ready backpressure and per-input grant statistics for the mesh NoC.

Parameters:
- WIDTH, 39, packet width in bits (dest x at [36:33], dest y at [32:29]; the arbiter does not inspect them).
- N_IN, 4, number of requesters (2..8).
- CNT_W, 16, width of each per-input grant counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N_IN  requester i has a packet.
- req_data  input  N_IN*WIDTH  packets, flattened; requester i occupies [i*WIDTH +: WIDTH].
- req_ready  output  N_IN  one-hot (or zero) accept strobe to requester i.
- out_valid  output  1  output register holds a packet.
- out_data  output  WIDTH  registered packet.
- out_ready  input  1  downstream accepts out_data this cycle.
- grant_id  output  $clog2(N_IN)  index of the requester whose packet is in out_data.
- stats_sel  input  $clog2(N_IN)  selects the counter shown on stats_count.
- stats_count  output  CNT_W  grant count of the selected requester (combinational read).

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, grant_id=0, rr pointer ptr=0, all grant counters=0, FSM=EMPTY.
  - req_ready=0 while reset is asserted.
  - A packet in flight is discarded. Requesters keep valid asserted and re-present after reset.
- FSM has two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Accept condition: accept = |req_valid && (state==EMPTY || out_ready).
- Winner: first i with req_valid[i]=1, searching ptr, ptr+1, …, N_IN-1, 0, …, ptr-1.
- req_ready[winner]=accept, asserted combinationally in the same cycle. All other req_ready bits are 0. At most one bit is ever set.
- On the clock edge with accept=1:
  - out_data <= req_data[winner]; grant_id <= winner; out_valid <= 1.
  - ptr <= (winner+1) mod N_IN.
  - count[winner] increments, saturating at all-ones.
- Transitions:
  - EMPTY & accept -> FULL.
  - FULL & out_ready & !accept -> EMPTY.
  - FULL & out_ready & accept -> FULL with the new packet (back-to-back, 1 packet/cycle).
  - FULL & !out_ready -> FULL; out_data and grant_id held stable; req_ready all 0.
- Requester rule: req_valid and req_data must stay stable until req_ready is seen. The arbiter never drops an accepted packet.
- Latency: a packet accepted at edge n appears on out_data after edge n (1 cycle).
- ptr advances only on an accept. With no requests, ptr holds.
- Simultaneous stats read and increment: stats_count shows the pre-increment value in that cycle.
- Fairness: with all inputs continuously valid and out_ready=1, the grant sequence is 0,1,…,N_IN-1,0,… Any requester waits at most N_IN-1 grants.

Decomposition:
- Shared noc_pkg holds:
  - WIDTH;
  - destination field offsets: X_MSB=36, X_LSB=33, Y_MSB=32, Y_LSB=29;
  - a port index enum (UP, DOWN, LEFT, RIGHT, LOCAL).
- One sub-module, rr_pick: purely combinational N_IN-bit priority search rotated by ptr. It returns the one-hot grant and the encoded index. It is reused by future input-buffer arbiters.

Test Plan:
- Single requester: req_valid=4'b0100, data 39'h0_1_1_00_0E_05_08, out_ready=1 -> req_ready=4'b0100 same cycle; next cycle out_valid=1, out_data=that packet, grant_id=2; ptr=3.
- All four valid continuously, distinct data, out_ready=1 -> grant_id sequence 0,1,2,3,0,1 on consecutive cycles; out_valid stays 1 (full throughput).
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles while FULL with req_valid=4'b1111.
  - Required: out_data and grant_id constant and req_ready=0 throughout.
  - Then out_ready=1 -> the next winner loads in the following cycle with no gap.
- Wrap and skip: ptr=3, req_valid=4'b0011 -> winner 0, then 1. Afterwards req_valid=4'b1000 -> winner 3, ptr wraps to 0.
- Counter saturation (CNT_W=4): 20 grants to input 1 -> stats_sel=1 gives stats_count=15; other counters 0.
- Reset mid-operation: rst_n=0 asynchronously while FULL, between clock edges -> out_valid=0 and req_ready=0 immediately. After release, arbitration restarts at ptr=0 and counters read 0.
